// File: rtl/alu_seq_pkg.sv
// Shared opcode encoding, sequencer state set and opcode-class helpers for alu_sequencer.
// The T_LD_* states exist only when ALU_SEQ_LOAD_EN is defined.
package alu_seq_pkg;
  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd3;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd4;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_AND  = 5'd9;
  localparam logic [OP_W-1:0] OP_OR   = 5'd10;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd11;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd12;
  localparam logic [OP_W-1:0] OP_MAX  = OP_NOT;

  typedef enum logic [2:0] {
    IDLE,
    T_Y,
    T_EXEC,
    T_WB,
    T_WB_HI
`ifdef ALU_SEQ_LOAD_EN
    ,
    T_LD_MDR,
    T_LD_WB
`endif
  } state_t;

  // Unary ops take their sole operand straight onto the bus in T_EXEC; Y is skipped.
  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_hilo(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction
endpackage

// File: rtl/alu_sequencer_dec.sv
// Register index to one-hot strobe decoder; all-zero when not enabled.
module reg_onehot_dec #(
  parameter int NREGS = 16,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic [IW-1:0]    idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);
  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    assign onehot[i] = en && (idx == IW'(i));
  end
endmodule

// File: rtl/alu_sequencer.sv
// T-state control sequencer for one register-to-register ALU command per handshake.
// Optional memory-load path (T_LD_MDR/T_LD_WB) is built only with ALU_SEQ_LOAD_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [IW-1:0]    cmd_dst,
  input  logic [IW-1:0]    cmd_srca,
  input  logic [IW-1:0]    cmd_srcb,
  input  logic             cmd_load,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic [OPW-1:0]   ALU_op,
  output logic             done,
  output logic             bad_op
);
  typedef struct packed {
    logic [OPW-1:0] op;
    logic [IW-1:0]  dst;
    logic [IW-1:0]  srca;
    logic [IW-1:0]  srcb;
  } cmd_t;

  state_t          state, state_nx;
  cmd_t            cmd_q;
  logic            accept, ld_in, op_bad_in, done_nx;
  logic            rout_en, rin_en;
  logic [IW-1:0]   rout_idx;
  logic [OP_W-1:0] op_in_c, op_q_c;

  assign cmd_ready = (state == IDLE) && !clear;
  assign accept    = cmd_valid && cmd_ready;
  // Out-of-range opcodes never reach the low bits used by the class helpers.
  assign op_in_c   = OP_W'(cmd_op);
  assign op_q_c    = OP_W'(cmd_q.op);

`ifdef ALU_SEQ_LOAD_EN
  assign ld_in = cmd_load;
`else
  logic unused_load;
  assign ld_in       = 1'b0;
  assign unused_load = cmd_load;
`endif

  assign op_bad_in = !ld_in && (cmd_op > OPW'(OP_MAX));

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      done   <= 1'b0;
      bad_op <= 1'b0;
    end else begin
      state  <= state_nx;
      done   <= done_nx;
      bad_op <= accept && op_bad_in;
    end
    if (accept) cmd_q <= '{op: cmd_op, dst: cmd_dst, srca: cmd_srca, srcb: cmd_srcb};
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    rout_en  = 1'b0;
    rout_idx = cmd_q.srca;
    rin_en   = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    ALU_op   = '0;
    case (state)
      IDLE: begin
        if (accept && !op_bad_in) begin
`ifdef ALU_SEQ_LOAD_EN
          if (cmd_load) state_nx = T_LD_MDR;
          else
`endif
          if (is_unary(op_in_c)) state_nx = T_EXEC;
          else                   state_nx = T_Y;
        end
      end
      T_Y: begin
        rout_en  = 1'b1;
        Yin      = 1'b1;
        state_nx = T_EXEC;
      end
      T_EXEC: begin
        rout_en  = 1'b1;
        rout_idx = is_unary(op_q_c) ? cmd_q.srca : cmd_q.srcb;
        Zin      = 1'b1;
        ALU_op   = cmd_q.op;
        state_nx = T_WB;
      end
      T_WB: begin
        Zlowout = 1'b1;
        if (is_hilo(op_q_c)) begin
          LOin     = 1'b1;
          state_nx = T_WB_HI;
        end else begin
          rin_en   = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      T_WB_HI: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
`ifdef ALU_SEQ_LOAD_EN
      T_LD_MDR: begin
        Read     = 1'b1;
        MDRin    = 1'b1;
        state_nx = T_LD_WB;
      end
      T_LD_WB: begin
        MDRout   = 1'b1;
        rin_en   = 1'b1;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  reg_onehot_dec #(.NREGS(NREGS), .IW(IW)) u_rout_dec (
    .idx   (rout_idx),
    .en    (rout_en),
    .onehot(Rout)
  );

  reg_onehot_dec #(.NREGS(NREGS), .IW(IW)) u_rin_dec (
    .idx   (cmd_q.dst),
    .en    (rin_en),
    .onehot(Rin)
  );
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: per-cycle expected strobe trace plus a small DataPath model.
module tb_alu_sequencer;
  localparam logic [31:0] MEM_WORD = 32'hDEADBEEF;

  logic        clock, clear, cmd_valid, cmd_ready, cmd_load;
  logic [4:0]  cmd_op, ALU_op;
  logic [3:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic [15:0] Rin, Rout;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin, Read, MDRin, MDRout, done, bad_op;

  alu_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_load(cmd_load), .Rin(Rin), .Rout(Rout), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .ALU_op(ALU_op),
    .done(done), .bad_op(bad_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin, rout;
    logic yin, zin, zlo, zhi, lo, hi, rd, mdrin, mdrout;
    logic [4:0] op;
    logic done, bad;
  } snap_t;

  snap_t got, mon_e;
  snap_t exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic mon_en = 1'b0, dp_init = 1'b1;

  always_comb got = {Rin, Rout, Yin, Zin, Zlowout, Zhighout, LOin, HIin, Read, MDRin, MDRout,
                     ALU_op, done, bad_op};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Every cycle's outputs must match the scoreboard front, or all-zero when nothing is in flight.
  always @(negedge clock) begin
    if (mon_en) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else                  mon_e = '0;
      chk("trace", 64'(got), 64'(mon_e));
    end
  end

  // ---- DataPath model driven by the DUT strobes ----
  logic [31:0] R [16];
  logic [31:0] Y, LO, HI, MDR, bus;
  logic [63:0] Z;

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      5'd0:    return {32'h0, y + b};
      5'd1:    return {32'h0, y - b};
      5'd2:    return 64'(y) * 64'(b);
      5'd3:    return (b == 32'h0) ? 64'h0 : {y % b, y / b};
      5'd4:    return {32'h0, y >> sh};
      5'd5:    return {32'h0, 32'($signed(y) >>> sh)};
      5'd6:    return {32'h0, y << sh};
      5'd7:    return {32'h0, (y >> sh) | (y << (6'd32 - {1'b0, sh}))};
      5'd8:    return {32'h0, (y << sh) | (y >> (6'd32 - {1'b0, sh}))};
      5'd9:    return {32'h0, y & b};
      5'd10:   return {32'h0, y | b};
      5'd11:   return {32'h0, -b};
      5'd12:   return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus |= R[i];
    if (Zlowout)  bus |= Z[31:0];
    if (Zhighout) bus |= Z[63:32];
    if (MDRout)   bus |= MDR;
  end

  always @(posedge clock) begin
    if (dp_init) begin
      for (int i = 0; i < 16; i++) R[i] <= 32'h0;
      R[1] <= 32'd3;  R[3] <= 32'd7;  R[5] <= 32'h34; R[6] <= 32'h45;
      R[7] <= 32'd9;  R[8] <= 32'h10; R[9] <= 32'h05;
      Y <= '0; Z <= '0; LO <= '0; HI <= '0; MDR <= '0;
    end else begin
      if (Yin)  Y <= bus;
      if (Zin)  Z <= alu(ALU_op, Y, bus);
      for (int i = 0; i < 16; i++) if (Rin[i]) R[i] <= bus;
      if (LOin) LO <= bus;
      if (HIin) HI <= bus;
      if (Read && MDRin) MDR <= MEM_WORD;
    end
  end

  // ---- expected per-cycle trace for one accepted command ----
  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] v;
    v = 16'h1;
    return v << i;
  endfunction

  task automatic push_exp(input logic [4:0] op, input logic [3:0] dst, a, b, input logic ld);
    snap_t s;
    logic  use_ld, un, hl;
    use_ld = 1'b0;
`ifdef ALU_SEQ_LOAD_EN
    use_ld = ld;
`endif
    un = (op == 5'd11) || (op == 5'd12);
    hl = (op == 5'd2)  || (op == 5'd3);
    if (use_ld) begin
      s = '0; s.rd = 1'b1; s.mdrin = 1'b1;  exp_q.push_back(s);
      s = '0; s.mdrout = 1'b1; s.rin = oh(dst); exp_q.push_back(s);
      s = '0; s.done = 1'b1;                exp_q.push_back(s);
    end else if (op > 5'd12) begin
      s = '0; s.bad = 1'b1;                 exp_q.push_back(s);
    end else begin
      if (!un) begin s = '0; s.rout = oh(a); s.yin = 1'b1; exp_q.push_back(s); end
      s = '0; s.zin = 1'b1; s.op = op; s.rout = un ? oh(a) : oh(b); exp_q.push_back(s);
      s = '0; s.zlo = 1'b1;
      if (hl) s.lo = 1'b1; else s.rin = oh(dst);
      exp_q.push_back(s);
      if (hl) begin s = '0; s.zhi = 1'b1; s.hi = 1'b1; exp_q.push_back(s); end
      s = '0; s.done = 1'b1;                exp_q.push_back(s);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] dst, a, b, input logic ld,
                       output int acc);
    int n;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 40) begin @(negedge clock); n++; end
    if (n >= 40) chk("ready_timeout", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = a; cmd_srcb = b; cmd_load = ld;
    @(posedge clock);
    #1;
    acc = cyc;
    push_exp(op, dst, a, b, ld);
    // Fields are scrambled after acceptance: the DUT must have latched them.
    cmd_valid = 1'b0;
    cmd_op   = 5'($urandom); cmd_dst  = 4'($urandom);
    cmd_srca = 4'($urandom); cmd_srcb = 4'($urandom);
    cmd_load = 1'($urandom);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish within budget");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    clear = 1'b1; cmd_valid = 1'b1; cmd_op = 5'd0; cmd_dst = 4'd1; cmd_srca = 4'd2;
    cmd_srcb = 4'd3; cmd_load = 1'b0;
    repeat (2) @(posedge clock);
    #1 mon_en = 1'b1;
    @(negedge clock);
    chk("ready_in_clear", 64'(cmd_ready), 64'(0));
    chk("done_in_clear", 64'(done), 64'(0));
    clear = 1'b0; dp_init = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    chk("ready_idle", 64'(cmd_ready), 64'(1));

    issue(5'd9,  4'd2,  4'd5, 4'd6, 1'b0, a0);   // AND
    issue(5'd11, 4'd12, 4'd7, 4'd0, 1'b0, a0);   // NEG
    issue(5'd2,  4'd0,  4'd3, 4'd1, 1'b0, a0);   // MUL
    issue(5'd13, 4'd2,  4'd5, 4'd6, 1'b0, a0);   // invalid op
    issue(5'd0,  4'd10, 4'd8, 4'd9, 1'b0, a1);   // ADD
    issue(5'd1,  4'd11, 4'd8, 4'd9, 1'b0, a2);   // SUB back-to-back
    chk("bad_to_add_gap", 64'(a1 - a0), 64'(1));
    chk("b2b_spacing", 64'(a2 - a1), 64'(4));
    issue(5'd0,  4'd4,  4'd5, 4'd6, 1'b1, a0);   // load (ALU ADD without the macro)

    // DIV interrupted by clear in T_EXEC: only T_Y and T_EXEC may be seen.
    issue(5'd3,  4'd0,  4'd8, 4'd9, 1'b0, a0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1 chk("ready_clear_midop", 64'(cmd_ready), 64'(0));
    @(negedge clock);
    clear = 1'b0;
    repeat (6) @(negedge clock);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("R2_and", 64'(R[2]),   64'(32'h04));
    chk("R12_neg", 64'(R[12]), 64'(32'hFFFFFFF7));
    chk("LO_mul", 64'(LO),     64'(32'h15));
    chk("HI_mul", 64'(HI),     64'(32'h0));
    chk("R10_add", 64'(R[10]), 64'(32'h15));
    chk("R11_sub", 64'(R[11]), 64'(32'h0B));
`ifdef ALU_SEQ_LOAD_EN
    chk("R4_load", 64'(R[4]),  64'(MEM_WORD));
`else
    chk("R4_load", 64'(R[4]),  64'(32'h79));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
